// File: rtl/udt_pkg.sv
// ----------------------------------------------------------------------------
// udt_pkg
// Shared definitions for the UDT transmit-path arbiter slice.
//   DATA_W         : payload width of every stream in the slice (64)
//   KEEP_W         : byte-enable width (8)
//   MAX_BEATS_DEF  : default longest legal packet, in beats (190)
//   arb_state_t    : arbiter FSM states IDLE, GNT0, GNT1, DRAIN0, DRAIN1
// ----------------------------------------------------------------------------
package udt_pkg;

   localparam int DATA_W        = 64;
   localparam int KEEP_W        = 8;
   localparam int MAX_BEATS_DEF = 190;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GNT0   = 3'd1,
      GNT1   = 3'd2,
      DRAIN0 = 3'd3,
      DRAIN1 = 3'd4
   } arb_state_t;

endpackage

// File: rtl/udt_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// udt_tx_arbiter_if
// AXI-Stream-style beat bundle used for both arbiter inputs and its output.
//   tdata  : DATA_W payload
//   tkeep  : KEEP_W byte enables
//   tvalid : beat valid
//   tlast  : last beat of the packet
//   tready : sink accepts the beat when high together with tvalid
// Modports:
//   master : drives tdata/tkeep/tvalid/tlast, samples tready
//   slave  : samples tdata/tkeep/tvalid/tlast, drives tready
// ----------------------------------------------------------------------------
interface udt_tx_arbiter_if;
   import udt_pkg::*;

   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic              tvalid;
   logic              tlast;
   logic              tready;

   modport master (
      output tdata,
      output tkeep,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tkeep,
      input  tvalid,
      input  tlast,
      output tready
   );

endinterface

// File: rtl/udt_axis_reg.sv
// ----------------------------------------------------------------------------
// udt_axis_reg
// Single-stage registered output for the arbiter. The register may take a new
// beat whenever it is empty or its current beat leaves this cycle; that
// condition is exported as adv so the arbiter can gate the granted source.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   load                   : capture in_data/in_keep/in_last this cycle
//   in_data/in_keep/in_last: beat to capture
//   out_ready              : downstream ready
//   out_data/out_keep/out_valid/out_last : registered beat
//   adv                    : !out_valid || out_ready (combinational)
// ----------------------------------------------------------------------------
module udt_axis_reg
   import udt_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] in_data,
   input  logic [KEEP_W-1:0] in_keep,
   input  logic              in_last,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [KEEP_W-1:0] out_keep,
   output logic              out_valid,
   output logic              out_last,
   output logic              adv
);

   // The slot frees up in the same cycle the downstream takes the beat, so a
   // streaming source sees no bubble between consecutive beats.
   assign adv = !out_valid || out_ready;

   // A new beat always wins over draining; valid only drops when the held beat
   // leaves and nothing replaces it. Payload is left as-is when valid drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
      end else if (load) begin
         out_data  <= in_data;
         out_keep  <= in_keep;
         out_last  <= in_last;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/udt_tx_arbiter.sv
// ----------------------------------------------------------------------------
// udt_tx_arbiter
// Two-to-one whole-packet arbiter in front of the UDT keep/byte-order reversal
// stage. Channel 0 carries data packets, channel 1 control packets
// (ACK/NAK/keep-alive). A packet, once granted, owns the output until its
// tlast beat is accepted, so beats of the two channels never interleave.
// Packets longer than MAX_BEATS are cut: the MAX_BEATS-th beat goes out with
// tlast forced, trunc_err pulses, and the rest of the source packet is
// swallowed in a DRAIN state.
//
// Parameters:
//   MAX_BEATS : longest legal packet in beats
//   CNT_W     : width of the per-channel packet counters
// Ports:
//   core_clk, core_rst_n     : clock, asynchronous active-low reset
//   ch0, ch1 (slave)         : data / control packet sources
//   out (master)             : registered output stream
//   ch0_pkt_cnt, ch1_pkt_cnt : completed packets per channel (wrapping)
//   trunc_err                : one-cycle pulse per force-terminated packet
//
// Build option:
//   CTRL_PRIORITY_EN : when defined, channel 1 wins every contested
//                      arbitration and the round-robin pointer is ignored;
//                      otherwise contested arbitrations alternate.
// ----------------------------------------------------------------------------
module udt_tx_arbiter
   import udt_pkg::*;
#(
   parameter int MAX_BEATS = MAX_BEATS_DEF,
   parameter int CNT_W     = 16
)(
   input  logic              core_clk,
   input  logic              core_rst_n,
   udt_tx_arbiter_if.slave   ch0,
   udt_tx_arbiter_if.slave   ch1,
   udt_tx_arbiter_if.master  out,
   output logic [CNT_W-1:0]  ch0_pkt_cnt,
   output logic [CNT_W-1:0]  ch1_pkt_cnt,
   output logic              trunc_err
);

   localparam int BC_W = $clog2(MAX_BEATS + 1);
   localparam logic [BC_W-1:0] BEAT_LIMIT = BC_W'(MAX_BEATS - 1);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic              rr_ptr;
   logic              rr_nxt;
   logic [BC_W-1:0]   beat_cnt;
   logic [BC_W-1:0]   beat_nxt;
   logic              trunc_nxt;
   logic              pkt_done0;
   logic              pkt_done1;

   logic              sel1;
   logic              src_rdy;
   logic              adv;
   logic              load;
   logic              ld_last;

   logic              g_valid;
   logic              g_last;
   logic [DATA_W-1:0] g_data;
   logic [KEEP_W-1:0] g_keep;

   // Winner of one arbitration round given both valids and the preferred
   // channel. A lone requester always wins; only ties consult the preference.
   function automatic arb_state_t arb_pick(input logic v0, input logic v1,
                                           input logic ptr);
      arb_state_t pick;
      pick = IDLE;
      if (v0 && v1) begin
`ifdef CTRL_PRIORITY_EN
         pick = GNT1;
`else
         pick = ptr ? GNT1 : GNT0;
`endif
      end else if (v0) begin
         pick = GNT0;
      end else if (v1) begin
         pick = GNT1;
      end
      return pick;
   endfunction

   // Both the granted and the draining state of a channel look at the same
   // source, so one select steers the input mux and the tready fan-out.
   assign sel1    = (state == GNT1) || (state == DRAIN1);
   assign g_valid = sel1 ? ch1.tvalid : ch0.tvalid;
   assign g_last  = sel1 ? ch1.tlast  : ch0.tlast;
   assign g_data  = sel1 ? ch1.tdata  : ch0.tdata;
   assign g_keep  = sel1 ? ch1.tkeep  : ch0.tkeep;

   assign ch0.tready = src_rdy && !sel1;
   assign ch1.tready = src_rdy && sel1;

   // Next-state and datapath control. A packet end (real tlast or truncation)
   // flips the round-robin pointer; a real end re-arbitrates in the same cycle
   // using the flipped pointer so back-to-back packets run without a bubble.
   // Truncation instead parks in DRAINx, where the source is always ready and
   // nothing is loaded, until the source's own tlast goes by.
   always_comb begin
      state_nxt = state;
      rr_nxt    = rr_ptr;
      beat_nxt  = beat_cnt;
      trunc_nxt = 1'b0;
      pkt_done0 = 1'b0;
      pkt_done1 = 1'b0;
      src_rdy   = 1'b0;
      load      = 1'b0;
      ld_last   = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = arb_pick(ch0.tvalid, ch1.tvalid, rr_ptr);
         end
         GNT0, GNT1: begin
            src_rdy = adv;
            if (g_valid && adv) begin
               load    = 1'b1;
               ld_last = g_last;
               if (g_last) begin
                  beat_nxt  = '0;
                  rr_nxt    = !sel1;
                  pkt_done0 = !sel1;
                  pkt_done1 = sel1;
                  state_nxt = arb_pick(ch0.tvalid, ch1.tvalid, !sel1);
               end else if (beat_cnt == BEAT_LIMIT) begin
                  ld_last   = 1'b1;
                  trunc_nxt = 1'b1;
                  beat_nxt  = '0;
                  rr_nxt    = !sel1;
                  state_nxt = sel1 ? DRAIN1 : DRAIN0;
               end else begin
                  beat_nxt = beat_cnt + 1'b1;
               end
            end
         end
         DRAIN0, DRAIN1: begin
            src_rdy = 1'b1;
            if (g_valid && g_last) begin
               state_nxt = arb_pick(ch0.tvalid, ch1.tvalid, rr_ptr);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Control state: FSM, arbitration pointer, in-packet beat count and the
   // truncation pulse, which lines up with the forced-tlast beat on the output.
   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         beat_cnt  <= '0;
         trunc_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_nxt;
         beat_cnt  <= beat_nxt;
         trunc_err <= trunc_nxt;
      end
   end

   // Per-channel completed-packet counters; truncated packets are not counted
   // and the counters simply wrap.
   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         ch0_pkt_cnt <= '0;
         ch1_pkt_cnt <= '0;
      end else begin
         if (pkt_done0) begin
            ch0_pkt_cnt <= ch0_pkt_cnt + 1'b1;
         end
         if (pkt_done1) begin
            ch1_pkt_cnt <= ch1_pkt_cnt + 1'b1;
         end
      end
   end

   udt_axis_reg u_out_reg (
      .clk       (core_clk),
      .rst_n     (core_rst_n),
      .load      (load),
      .in_data   (g_data),
      .in_keep   (g_keep),
      .in_last   (ld_last),
      .out_ready (out.tready),
      .out_data  (out.tdata),
      .out_keep  (out.tkeep),
      .out_valid (out.tvalid),
      .out_last  (out.tlast),
      .adv       (adv)
   );

endmodule

// File: tb/tb_udt_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_udt_tx_arbiter
// Directed bench for udt_tx_arbiter built with MAX_BEATS = 4 so truncation is
// reachable with short packets. Payload words encode channel, packet and beat
// so the observed output order can be compared against hand-derived order.
// Expectations for the contested-arbitration scenario follow CTRL_PRIORITY_EN.
// ----------------------------------------------------------------------------
module tb_udt_tx_arbiter;
   import udt_pkg::*;

   localparam int TB_MAX_BEATS = 4;
   localparam int WAIT_LIMIT   = 200;

   logic        core_clk;
   logic        core_rst_n;
   logic [15:0] ch0_pkt_cnt;
   logic [15:0] ch1_pkt_cnt;
   logic        trunc_err;

   udt_tx_arbiter_if ch0_if ();
   udt_tx_arbiter_if ch1_if ();
   udt_tx_arbiter_if out_if ();

   udt_tx_arbiter #(
      .MAX_BEATS (TB_MAX_BEATS),
      .CNT_W     (16)
   ) dut (
      .core_clk    (core_clk),
      .core_rst_n  (core_rst_n),
      .ch0         (ch0_if),
      .ch1         (ch1_if),
      .out         (out_if),
      .ch0_pkt_cnt (ch0_pkt_cnt),
      .ch1_pkt_cnt (ch1_pkt_cnt),
      .trunc_err   (trunc_err)
   );

   int testsRun    = 0;
   int testsFailed = 0;

   logic [63:0] capData[$];
   logic [7:0]  capKeep[$];
   logic        capLast[$];
   int          capCycle[$];
   int          cycleNum        = 0;
   int          truncPulses     = 0;
   int          ch1ReadyCycles  = 0;

   // Free-running clock, 10 time units per cycle.
   initial begin
      core_clk = 1'b0;
      forever #5 core_clk = ~core_clk;
   end

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation still running, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Output monitor on the falling edge: records every transferred beat with
   // its cycle number, and counts trunc_err pulses and ch1 ready cycles.
   always @(negedge core_clk) begin
      cycleNum = cycleNum + 1;
      if (core_rst_n && out_if.tvalid && out_if.tready) begin
         capData.push_back(out_if.tdata);
         capKeep.push_back(out_if.tkeep);
         capLast.push_back(out_if.tlast);
         capCycle.push_back(cycleNum);
      end
      if (trunc_err) truncPulses = truncPulses + 1;
      if (ch1_if.tready) ch1ReadyCycles = ch1ReadyCycles + 1;
   end

   function automatic logic [63:0] mkData(input int ch, input int pkt, input int beat);
      return 64'hA5A5_0000_0000_0000 | (64'(ch) << 16) | (64'(pkt) << 8) | 64'(beat);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testsRun = testsRun + 1;
      if (obs !== exp) begin
         testsFailed = testsFailed + 1;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic setChannel(input int ch, input logic v, input logic [63:0] d,
                             input logic [7:0] k, input logic l);
      if (ch == 0) begin
         ch0_if.tvalid = v; ch0_if.tdata = d; ch0_if.tkeep = k; ch0_if.tlast = l;
      end else begin
         ch1_if.tvalid = v; ch1_if.tdata = d; ch1_if.tkeep = k; ch1_if.tlast = l;
      end
   endtask

   // Source driver: presents one packet beat by beat, holding each beat until
   // it is accepted; gives up (timedOut = 1) if a beat waits too long.
   task automatic applyStimulus(input int ch, input int nbeats, input int pkt,
                                output bit timedOut);
      bit acc;
      int waitCnt;
      timedOut = 1'b0;
      for (int b = 0; b < nbeats; b++) begin
         setChannel(ch, 1'b1, mkData(ch, pkt, b),
                    (b == nbeats - 1) ? 8'h0F : 8'hFF, b == nbeats - 1);
         waitCnt = 0;
         forever begin
            @(negedge core_clk);
            acc = (ch == 0) ? (ch0_if.tvalid && ch0_if.tready)
                            : (ch1_if.tvalid && ch1_if.tready);
            @(posedge core_clk);
            #1;
            if (acc) break;
            waitCnt++;
            if (waitCnt > WAIT_LIMIT) begin
               timedOut = 1'b1;
               break;
            end
         end
         if (timedOut) break;
      end
      setChannel(ch, 1'b0, 64'h0, 8'h00, 1'b0);
   endtask

   task automatic doReset();
      core_rst_n    = 1'b0;
      setChannel(0, 1'b0, 64'h0, 8'h00, 1'b0);
      setChannel(1, 1'b0, 64'h0, 8'h00, 1'b0);
      out_if.tready = 1'b1;
      repeat (2) @(posedge core_clk);
      #1;
      core_rst_n = 1'b1;
      capData.delete();
      capKeep.delete();
      capLast.delete();
      capCycle.delete();
      truncPulses    = 0;
      ch1ReadyCycles = 0;
   endtask

   initial begin
      bit to0, to1, t;
      int nExp;
      int waitCnt;

      // ---------------- reset values ----------------
      doReset();
      checkOutput("rst_out_tvalid", out_if.tvalid, 1'b0);
      checkOutput("rst_out_tdata",  out_if.tdata,  64'h0);
      checkOutput("rst_out_tlast",  out_if.tlast,  1'b0);
      checkOutput("rst_ch0_cnt",    ch0_pkt_cnt,   16'h0);
      checkOutput("rst_ch1_cnt",    ch1_pkt_cnt,   16'h0);
      checkOutput("rst_trunc",      trunc_err,     1'b0);
      checkOutput("rst_ch0_tready", ch0_if.tready, 1'b0);
      checkOutput("rst_ch1_tready", ch1_if.tready, 1'b0);

      // ---------------- single ch0 3-beat packet ----------------
      applyStimulus(0, 3, 0, t);
      repeat (3) @(posedge core_clk);
      #1;
      checkOutput("single_timeout", t, 1'b0);
      checkOutput("single_count", capData.size(), 3);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("single_data%0d", i),
                     (i < capData.size()) ? capData[i] : 64'h0, mkData(0, 0, i));
         checkOutput($sformatf("single_keep%0d", i),
                     (i < capKeep.size()) ? capKeep[i] : 8'h00, (i == 2) ? 8'h0F : 8'hFF);
         checkOutput($sformatf("single_last%0d", i),
                     (i < capLast.size()) ? capLast[i] : 1'b0, i == 2);
      end
      checkOutput("single_ch0_cnt", ch0_pkt_cnt, 16'd1);
      checkOutput("single_ch1_ready_cycles", ch1ReadyCycles, 0);

      // ---------------- both channels, 3 x 2-beat packets each ----------------
      doReset();
      to0 = 1'b0;
      to1 = 1'b0;
      fork
         begin
            for (int p = 0; p < 3; p++) begin
               bit tt;
               applyStimulus(0, 2, p, tt);
               to0 |= tt;
            end
         end
         begin
            for (int p = 0; p < 3; p++) begin
               bit tt;
               applyStimulus(1, 2, p, tt);
               to1 |= tt;
            end
         end
      join
      repeat (3) @(posedge core_clk);
      #1;
`ifdef CTRL_PRIORITY_EN
      nExp = 6;
      checkOutput("both_ch0_timeout", to0, 1'b1);
      checkOutput("both_ch0_cnt", ch0_pkt_cnt, 16'd0);
`else
      nExp = 12;
      checkOutput("both_ch0_timeout", to0, 1'b0);
      checkOutput("both_ch0_cnt", ch0_pkt_cnt, 16'd3);
`endif
      checkOutput("both_ch1_timeout", to1, 1'b0);
      checkOutput("both_ch1_cnt", ch1_pkt_cnt, 16'd3);
      checkOutput("both_count", capData.size(), nExp);
      for (int i = 0; i < nExp; i++) begin
         int pk, ch, p;
         pk = i / 2;
`ifdef CTRL_PRIORITY_EN
         ch = 1;
         p  = pk;
`else
         ch = pk % 2;
         p  = pk / 2;
`endif
         checkOutput($sformatf("both_beat%0d", i),
                     (i < capData.size()) ? capData[i] : 64'h0, mkData(ch, p, i % 2));
         checkOutput($sformatf("both_last%0d", i),
                     (i < capLast.size()) ? capLast[i] : 1'b0, (i % 2) == 1);
      end
      checkOutput("both_no_bubble",
                  (capCycle.size() == nExp) ? (capCycle[nExp-1] - capCycle[0]) : -1,
                  nExp - 1);

      // ---------------- downstream stall for 5 cycles ----------------
      doReset();
      fork
         applyStimulus(0, 3, 0, t);
         begin
            waitCnt = 0;
            do begin
               @(negedge core_clk);
               waitCnt++;
            end while (!out_if.tvalid && waitCnt < WAIT_LIMIT);
            checkOutput("stall_first_valid", out_if.tvalid, 1'b1);
            @(posedge core_clk);
            #1;
            out_if.tready = 1'b0;
            repeat (5) begin
               @(negedge core_clk);
               checkOutput("stall_data",   out_if.tdata,  mkData(0, 0, 1));
               checkOutput("stall_valid",  out_if.tvalid, 1'b1);
               checkOutput("stall_tready", ch0_if.tready, 1'b0);
            end
            checkOutput("stall_captured", capData.size(), 1);
            @(posedge core_clk);
            #1;
            out_if.tready = 1'b1;
         end
      join
      repeat (3) @(posedge core_clk);
      #1;
      checkOutput("stall_timeout", t, 1'b0);
      checkOutput("stall_count", capData.size(), 3);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("stall_beat%0d", i),
                     (i < capData.size()) ? capData[i] : 64'h0, mkData(0, 0, i));
      end
      checkOutput("stall_ch0_cnt", ch0_pkt_cnt, 16'd1);

      // ---------------- truncation: 6-beat packet, limit 4 ----------------
      doReset();
      applyStimulus(0, 6, 0, t);
      repeat (3) @(posedge core_clk);
      #1;
      checkOutput("trunc_timeout", t, 1'b0);
      checkOutput("trunc_count", capData.size(), 4);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("trunc_beat%0d", i),
                     (i < capData.size()) ? capData[i] : 64'h0, mkData(0, 0, i));
         checkOutput($sformatf("trunc_last%0d", i),
                     (i < capLast.size()) ? capLast[i] : 1'b0, i == 3);
      end
      checkOutput("trunc_pulses", truncPulses, 1);
      checkOutput("trunc_ch0_cnt", ch0_pkt_cnt, 16'd0);

      // ---------------- reset in the middle of a packet ----------------
      doReset();
      applyStimulus(0, 2, 0, t);
      checkOutput("midrst_first_timeout", t, 1'b0);
      setChannel(0, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0);
      repeat (2) @(posedge core_clk);
      #1;
      checkOutput("midrst_pre_valid", out_if.tvalid, 1'b1);
      checkOutput("midrst_pre_data",  out_if.tdata,  64'hDEAD_BEEF_0000_0001);
      checkOutput("midrst_pre_cnt",   ch0_pkt_cnt,   16'd1);
      core_rst_n = 1'b0;
      #1;
      checkOutput("midrst_out_tvalid", out_if.tvalid, 1'b0);
      checkOutput("midrst_out_tdata",  out_if.tdata,  64'h0);
      checkOutput("midrst_out_tkeep",  out_if.tkeep,  8'h00);
      checkOutput("midrst_out_tlast",  out_if.tlast,  1'b0);
      checkOutput("midrst_ch0_cnt",    ch0_pkt_cnt,   16'd0);
      checkOutput("midrst_ch0_tready", ch0_if.tready, 1'b0);
      checkOutput("midrst_trunc",      trunc_err,     1'b0);
      setChannel(0, 1'b0, 64'h0, 8'h00, 1'b0);
      repeat (2) @(posedge core_clk);
      #1;
      core_rst_n = 1'b1;
      repeat (2) @(posedge core_clk);
      #1;
      checkOutput("midrst_idle_tready", ch0_if.tready, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
